stopwatch_sampler: RTL
======================

Name: stopwatch_sampler

Overview:
- Clocked control and capture stage that sits around the self-timed 3-bit gate-delay stopwatch.
- Drives the stopwatch's "first" clear input (F) and waits for the dynamic adder's asynchronous completion signal.
- Samples the stopwatch count at completion and returns it to the system over a valid/ready channel.
- Keeps running latency statistics (count, min, max, sum) for characterisation of the dynamic adder.

Parameters:
- CW, 3, stopwatch count width.
- SYNC_STAGES, 2, flops in the done synchroniser and in the matching count delay line (min 2).
- F_HOLD, 2, cycles sw_f is held high in ARM before release (min 1).
- TIMEOUT, 15, max RUN cycles before abort (min 1).
- ACC_W, 16, width of the stat_n and stat_sum accumulators.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request one timed measurement.
- req_ready  out  1  high only in IDLE.
- sw_f  out  1  F input of the stopwatch; 1 holds the stopwatch cleared.
- sw_count  in  CW  stopwatch count outputs c[CW-1:0].
- done_async  in  1  adder completion, asynchronous, level.
- res_valid  out  1  result available.
- res_ready  in  1  result consumed.
- res_count  out  CW  captured count; 0 when timed out.
- res_timeout  out  1  measurement aborted by timeout.
- stat_clr  in  1  synchronous clear of all statistics, sampled every cycle.
- stat_n  out  ACC_W  number of successful (non-timeout) measurements.
- stat_min  out  CW  minimum captured count.
- stat_max  out  CW  maximum captured count.
- stat_sum  out  ACC_W  sum of captured counts.

Behaviour:
- Reset is asynchronous and active-low, on rst_n. Reset values:
  - state=IDLE, sw_f=1, req_ready=1, res_valid=0, res_count=0, res_timeout=0;
  - stat_n=0, stat_sum=0, stat_max=0, stat_min=all-ones;
  - synchroniser and delay-line flops all 0.
- Input conditioning:
  - done_async passes through a SYNC_STAGES-deep synchroniser to give done_s.
  - sw_count is registered through a SYNC_STAGES-deep delay line so the count reaching the capture register is aligned with done_s.
  - done_rise = done_s & ~done_s_prev.
- FSM states:
  - IDLE:
    - sw_f=1, req_ready=1.
    - On req_valid, go to ARM with hold_cnt=0.
  - ARM:
    - sw_f=1, hold_cnt increments each cycle.
    - When hold_cnt==F_HOLD-1, go to RUN with run_cnt=0.
    - If done_s is already high in the last ARM cycle, still go to RUN; RUN then waits for a fresh rising edge.
  - RUN:
    - sw_f=0, run_cnt increments each cycle.
    - done_rise: capture the delayed count, go to REPORT, res_timeout=0.
    - run_cnt==TIMEOUT-1 without done_rise: res_count=0, res_timeout=1, go to REPORT.
    - done_rise and timeout in the same cycle: done wins.
  - REPORT:
    - sw_f=1 (re-clear the stopwatch immediately), res_valid=1.
    - res_count and res_timeout are stable while res_valid && !res_ready.
    - On res_ready, go to IDLE and drop res_valid the next cycle.
- Statistics:
  - Updated once, in the cycle RUN→REPORT on a successful capture only.
  - stat_n+=1, stat_sum+=zero-extended count; both saturate at all-ones with no wrap.
  - min/max updated by unsigned compare.
  - stat_clr has priority over an update in the same cycle. It does not disturb the FSM.
- Latency:
  - req_valid → sw_f falls after F_HOLD+1 cycles.
  - Edge on done_async → res_valid within SYNC_STAGES+2 cycles.
- Stopwatch wrap: a count that wrapped past 2^CW-1 is reported modulo; no detection is required.
- Reset mid-RUN: sw_f returns to 1 asynchronously; the result is discarded and statistics are cleared.

Decomposition:
- Shared package holds:
  - FSM state enum {IDLE, ARM, RUN, REPORT};
  - default-parameter constants;
  - a result struct {count, timeout}.
- One natural sub-module: sync_delay_line, a parameterised N-stage, W-bit flop chain with async active-low reset. It is instantiated twice: for done_async (W=1) and for sw_count (W=CW).

Test Plan:
- Reset then a single request; done_async rises 4 cycles after sw_f falls, sw_count model =5 → res_valid with res_count=5, res_timeout=0; stat_n=1, stat_min=stat_max=5, stat_sum=5.
- No done_async for TIMEOUT=15 RUN cycles → res_timeout=1, res_count=0; stats unchanged; sw_f=1 in REPORT.
- Three measurements with counts 3, 7, 1 → stat_n=3, stat_min=1, stat_max=7, stat_sum=11.
- res_ready held low for 10 cycles in REPORT → res_valid and res_count stable; req_ready=0; a new req_valid is ignored until IDLE.
- rst_n pulsed low mid-RUN → sw_f=1 asynchronously; all outputs at reset values; the next request measures correctly.
- stat_clr asserted in the same cycle as a capture of count 6 → stats read reset values afterwards; res_count=6 still delivered.

Source files
------------

// File: rtl/stopwatch_sampler_pkg.sv
// Shared types and default constants for the stopwatch capture stage.
package stopwatch_sampler_pkg;

  localparam int unsigned DEF_CW          = 3;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_F_HOLD      = 2;
  localparam int unsigned DEF_TIMEOUT     = 15;
  localparam int unsigned DEF_ACC_W       = 16;

  // Measurement sequencing states
  typedef enum logic [1:0] {
    IDLE,
    ARM,
    RUN,
    REPORT
  } state_t;

  // One measurement result as returned to the system
  typedef struct packed {
    logic [DEF_CW-1:0] count;
    logic              timeout;
  } result_t;

endpackage

// File: rtl/stopwatch_sampler_sync.sv
// N-stage, W-bit flop chain with asynchronous active-low reset.
// Used both as a metastability synchroniser and as a matching delay line.
module sync_delay_line #(
  parameter int unsigned N = 2,
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [N-1:0][W-1:0] stage;

  // Shift the input through N flops; stage[N-1] is the oldest sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage <= '0;
    end else begin
      stage <= {stage[N-2:0], d};
    end
  end

  assign q = stage[N-1];

endmodule

// File: rtl/stopwatch_sampler.sv
// Clocked control/capture stage around the self-timed gate-delay stopwatch.
// Clears and releases the stopwatch, waits for the adder completion, captures
// the count, returns it over valid/ready and keeps latency statistics.
module stopwatch_sampler
  import stopwatch_sampler_pkg::*;
#(
  parameter int unsigned CW          = DEF_CW,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned F_HOLD      = DEF_F_HOLD,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT,
  parameter int unsigned ACC_W       = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  output logic             sw_f,
  input  logic [CW-1:0]    sw_count,
  input  logic             done_async,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CW-1:0]    res_count,
  output logic             res_timeout,
  input  logic             stat_clr,
  output logic [ACC_W-1:0] stat_n,
  output logic [CW-1:0]    stat_min,
  output logic [CW-1:0]    stat_max,
  output logic [ACC_W-1:0] stat_sum
);

  localparam int unsigned HW = $clog2(F_HOLD + 1);
  localparam int unsigned RW = $clog2(TIMEOUT + 1);
  localparam int unsigned SW = ACC_W + 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(F_HOLD - 1);
  localparam logic [RW-1:0] RUN_LAST  = RW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [RW-1:0] run_q, run_d;

  logic          done_s;
  logic          done_prev;
  logic          done_rise;
  logic [CW-1:0] cnt_d;

  logic          cap_en;
  logic          cap_timeout;
  logic          stat_upd;
  logic [SW-1:0] sum_ext;

  // Completion synchroniser
  sync_delay_line #(
    .N (SYNC_STAGES),
    .W (1)
  ) u_done_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (done_async),
    .q     (done_s)
  );

  // Count delay line of equal depth so cnt_d lines up with done_s
  sync_delay_line #(
    .N (SYNC_STAGES),
    .W (CW)
  ) u_count_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sw_count),
    .q     (cnt_d)
  );

  // Previous synchronised completion level for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_prev <= 1'b0;
    end else begin
      done_prev <= done_s;
    end
  end

  // A level already high when RUN starts produces no rise, so RUN waits
  // for a fresh completion edge.
  assign done_rise = done_s & ~done_prev;

  // State and cycle counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      run_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      run_q   <= run_d;
    end
  end

  // Next-state, counter and handshake decode; sw_f is decoded from state so
  // it returns high as soon as reset asserts.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    run_d       = run_q;
    cap_en      = 1'b0;
    cap_timeout = 1'b0;
    sw_f        = 1'b1;
    req_ready   = 1'b0;
    res_valid   = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d = ARM;
          hold_d  = '0;
        end
      end
      ARM: begin
        hold_d = hold_q + HW'(1);
        if (hold_q == HOLD_LAST) begin
          state_d = RUN;
          run_d   = '0;
        end
      end
      RUN: begin
        sw_f  = 1'b0;
        run_d = run_q + RW'(1);
        if (done_rise) begin
          cap_en  = 1'b1;
          state_d = REPORT;
        end else if (run_q == RUN_LAST) begin
          cap_en      = 1'b1;
          cap_timeout = 1'b1;
          state_d     = REPORT;
        end
      end
      REPORT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Result register: written only on leaving RUN, so it holds through REPORT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_count   <= '0;
      res_timeout <= 1'b0;
    end else if (cap_en) begin
      res_count   <= cap_timeout ? '0 : cnt_d;
      res_timeout <= cap_timeout;
    end
  end

  assign stat_upd = cap_en & ~cap_timeout;
  assign sum_ext  = {1'b0, stat_sum} + SW'(cnt_d);

  // Running statistics; clear beats a same-cycle update, counters saturate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_n   <= '0;
      stat_sum <= '0;
      stat_min <= '1;
      stat_max <= '0;
    end else if (stat_clr) begin
      stat_n   <= '0;
      stat_sum <= '0;
      stat_min <= '1;
      stat_max <= '0;
    end else if (stat_upd) begin
      stat_n   <= (stat_n == '1) ? stat_n : stat_n + ACC_W'(1);
      stat_sum <= sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
      if (cnt_d < stat_min) begin
        stat_min <= cnt_d;
      end
      if (cnt_d > stat_max) begin
        stat_max <= cnt_d;
      end
    end
  end

endmodule
